// File: rtl/fpsu_sched_pkg.sv
// Shared constants and helpers for the FP/SIMD writeback scheduler.
package fpsu_sched_pkg;

    localparam int NUM_PORTS = 3;

    // Issue-port indices, also the encoding of div_owner.
    localparam logic [1:0] P_U1 = 2'd0;
    localparam logic [1:0] P_U3 = 2'd1;
    localparam logic [1:0] P_U5 = 2'd2;

    localparam int DEPTH_DEF   = 32;
    localparam int DIV_LAT_DEF = 20;
    localparam int DIV_II_DEF  = 16;

    // Internal latency width: covers DEPTH up to 64, so both the 5-bit port
    // latency and DIV_LAT fit without truncation.
    localparam int LAT_W = 6;

    // A latency is schedulable when it lands strictly inside the table.
    function automatic logic lat_ok(input int unsigned l, input int unsigned depth = DEPTH_DEF);
        return (l >= 1) && (l < depth);
    endfunction

endpackage

// File: rtl/fpsu_resv_tbl.sv
// Per-port reservation table: one bit per future cycle, bit 0 is "result returns now".
module fpsu_resv_tbl
    import fpsu_sched_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [LAT_W-1:0] lat,
    input  logic             gnt,
    output logic             slot_free,
    output logic             wb_en
);

    logic [DEPTH-1:0] res;
    logic [DEPTH-1:0] res_nxt;
    logic             hit;

    // Slot-free test: the cycle the result would return must be unclaimed.
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (lat == LAT_W'(k)) hit = res[k];
        end
        slot_free = lat_ok(32'(lat), DEPTH) && !hit;
    end

    // Advance one cycle; a grant claims bit L-1 of the shifted table,
    // which is bit L as seen from the granting cycle.
    always_comb begin
        res_nxt = {1'b0, res[DEPTH-1:1]};
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (gnt && (lat == LAT_W'(k + 1))) res_nxt[k] = 1'b1;
        end
    end

    // Table register; reset and flush both drop every pending result.
    always_ff @(posedge clk) begin
        if (rst || clr) res <= '0;
        else            res <= res_nxt;
    end

    assign wb_en = res[0];

endmodule

// File: rtl/fpsu_wb_sched.sv
// Writeback-slot scheduler for ports u1/u3/u5 with a shared round-robin divider.
module fpsu_wb_sched
    import fpsu_sched_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int DIV_II  = DIV_II_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       u1_req,
    input  logic       u3_req,
    input  logic       u5_req,
    input  logic [4:0] u1_lat,
    input  logic [4:0] u3_lat,
    input  logic [4:0] u5_lat,
    input  logic       u1_div,
    input  logic       u3_div,
    input  logic       u5_div,
    output logic       u1_gnt,
    output logic       u3_gnt,
    output logic       u5_gnt,
    output logic       u1_wb_en,
    output logic       u3_wb_en,
    output logic       u5_wb_en,
    output logic       div_busy,
    output logic [1:0] div_owner
);

    localparam int CW = (DIV_II > 1) ? $clog2(DIV_II) : 1;

    logic [NUM_PORTS-1:0]            req;
    logic [NUM_PORTS-1:0]            div;
    logic [NUM_PORTS-1:0]            free;
    logic [NUM_PORTS-1:0]            cand;
    logic [NUM_PORTS-1:0]            gnt;
    logic [NUM_PORTS-1:0]            wb;
    logic [NUM_PORTS-1:0][4:0]       lat_in;
    logic [NUM_PORTS-1:0][LAT_W-1:0] lat_eff;

    logic [1:0]    rr;
    logic [1:0]    owner;
    logic [1:0]    win;
    logic          win_vld;
    logic [CW-1:0] cnt;
    logic          busy;

    assign req    = {u5_req, u3_req, u1_req};
    assign div    = {u5_div, u3_div, u1_div};
    assign lat_in = {u5_lat, u3_lat, u1_lat};

    // Divider stays blocked while its countdown is non-zero, so grants are
    // exactly DIV_II cycles apart.
    assign busy = (cnt != '0);

    genvar p;
    generate
        for (p = 0; p < NUM_PORTS; p++) begin : g_port
            assign lat_eff[p] = div[p] ? LAT_W'(DIV_LAT) : LAT_W'(lat_in[p]);

            fpsu_resv_tbl #(.DEPTH(DEPTH)) u_tbl (
                .clk       (clk),
                .rst       (rst),
                .clr       (flush),
                .lat       (lat_eff[p]),
                .gnt       (gnt[p]),
                .slot_free (free[p]),
                .wb_en     (wb[p])
            );
        end
    endgenerate

    // Divider arbitration: first eligible candidate at or after RR.
    always_comb begin
        int q;
        cand    = '0;
        win_vld = 1'b0;
        win     = rr;
        q       = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand[i] = req[i] & div[i] & free[i] & !busy & !flush & !rst;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            q = int'(rr) + o;
            if (q >= NUM_PORTS) q = q - NUM_PORTS;
            if (!win_vld && cand[q]) begin
                win_vld = 1'b1;
                win     = 2'(q);
            end
        end
    end

    // Grants: slot check per port, plus arbitration win for divide ops.
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            gnt[i] = !rst & !flush & req[i] & free[i] &
                     (div[i] ? (win_vld && (win == 2'(i))) : 1'b1);
        end
    end

    // Divider countdown, owner and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            rr    <= P_U1;
            owner <= P_U1;
        end else if (flush) begin
            cnt <= '0;
        end else if (win_vld) begin
            cnt   <= CW'(DIV_II - 1);
            owner <= win;
            rr    <= (win == P_U5) ? P_U1 : win + 2'd1;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign {u5_gnt, u3_gnt, u1_gnt}       = gnt;
    assign {u5_wb_en, u3_wb_en, u1_wb_en} = wb;
    assign div_busy  = busy;
    assign div_owner = owner;

endmodule
